// File: rtl/ecall_pkg.sv
// Shared CPU package for the ecall I/O unit.
// Holds the ecall service numbers and the state encoding of the ecall FSM.
package ecall_pkg;

   localparam logic [31:0] SVC_PRINT  = 32'd1;
   localparam logic [31:0] SVC_READ_U = 32'd5;
   localparam logic [31:0] SVC_READ_S = 32'd6;
   localparam logic [31:0] SVC_EXIT   = 32'd10;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_REL   = 3'd1,
      ST_WAIT_PRESS = 3'd2,
      ST_DONE       = 3'd3,
      ST_HALT       = 3'd4
   } ecall_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a registered rising-edge pulse.
// Rises are suppressed until the button has been seen released after reset.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [1:0]       r_vld;
   logic             r_level;
   logic             r_rise;
   logic             r_armed;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_low_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_vld     <= 2'b00;
         r_level   <= 1'b0;
         r_rise    <= 1'b0;
         r_armed   <= 1'b0;
         r_cnt     <= '0;
         r_low_cnt <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_vld   <= {r_vld[0], 1'b1};
         r_rise  <= 1'b0;
         // The counter stops at CNT_LAST because reaching it flips the level and clears it.
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
            r_rise  <= r_sync2 & r_armed;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // A press already held across reset must be released (stably) before any rise counts.
         if (!r_armed) begin
            if (r_vld[1] && !r_sync2) begin
               if (r_low_cnt == CNT_LAST) r_armed <= 1'b1;
               else                       r_low_cnt <= r_low_cnt + 1'b1;
            end else begin
               r_low_cnt <= '0;
            end
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/ecall_io_unit.sv
// Ecall I/O unit: services print, read (unsigned/signed) and exit ecalls from EX.
// Reads wait for the button to be released and then freshly pressed.
module ecall_io_unit
   import ecall_pkg::*;
#(
   parameter int SW_W            = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ecall,
   input  logic [31:0]     a0,
   input  logic [31:0]     a7,
   input  logic [SW_W-1:0] switches,
   input  logic            button,
   output logic            ecall_done,
   output logic            ecall_write,
   output logic [31:0]     ecall_result,
   output logic            ecall_wait,
   output logic            input_wait,
   output logic [31:0]     seg_data,
   output logic            halted
);

   ecall_state_t r_state;
   logic [31:0]  r_a7;
   logic         r_done;
   logic         r_write;
   logic [31:0]  r_result;
   logic [31:0]  r_seg;
   logic         r_ecall_wait;
   logic         r_input_wait;
   logic         r_halted;

   logic         w_btn_level;
   logic         w_btn_rise;
   logic [31:0]  w_zext;
   logic [31:0]  w_sext;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (button),
      .o_level(w_btn_level),
      .o_rise (w_btn_rise)
   );

   generate
      if (SW_W == 32) begin : g_full
         assign w_zext = switches;
         assign w_sext = switches;
      end else begin : g_ext
         assign w_zext = {{(32-SW_W){1'b0}}, switches};
         assign w_sext = {{(32-SW_W){switches[SW_W-1]}}, switches};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_a7         <= '0;
         r_done       <= 1'b0;
         r_write      <= 1'b0;
         r_result     <= '0;
         r_seg        <= '0;
         r_ecall_wait <= 1'b0;
         r_input_wait <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_write <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ecall) begin
                  r_a7 <= a7;
                  case (a7)
                     SVC_PRINT: begin
                        r_seg        <= a0;
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_ecall_wait <= 1'b1;
                     end
                     SVC_READ_U, SVC_READ_S: begin
                        r_state      <= ST_WAIT_REL;
                        r_ecall_wait <= 1'b1;
                        r_input_wait <= 1'b1;
                     end
                     SVC_EXIT: begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                     end
                     default: begin
                        r_state      <= ST_DONE;
                        r_done       <= 1'b1;
                        r_ecall_wait <= 1'b1;
                     end
                  endcase
               end
            end
            ST_WAIT_REL: begin
               if (!w_btn_level) r_state <= ST_WAIT_PRESS;
            end
            ST_WAIT_PRESS: begin
               if (w_btn_rise) begin
                  r_result     <= (r_a7 == SVC_READ_S) ? w_sext : w_zext;
                  r_state      <= ST_DONE;
                  r_done       <= 1'b1;
                  r_write      <= 1'b1;
                  r_input_wait <= 1'b0;
               end
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_ecall_wait <= 1'b0;
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state      <= ST_IDLE;
               r_ecall_wait <= 1'b0;
               r_input_wait <= 1'b0;
            end
         endcase
      end
   end

   assign ecall_done   = r_done;
   assign ecall_write  = r_write;
   assign ecall_result = r_result;
   assign ecall_wait   = r_ecall_wait;
   assign input_wait   = r_input_wait;
   assign seg_data     = r_seg;
   assign halted       = r_halted;

endmodule

// File: tb/tb_ecall_io_unit.sv
// Directed bench for ecall_io_unit at SW_W=8, DEBOUNCE_CYCLES=4.
// Table-driven print/NOP and read vectors plus hand-written bounce, exit and reset sequences.
module tb_ecall_io_unit;

   localparam int SW_W = 8;
   localparam int DB   = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ecall = 1'b0;
   logic [31:0]     a0 = '0;
   logic [31:0]     a7 = '0;
   logic [SW_W-1:0] switches = '0;
   logic            button = 1'b0;
   logic            ecall_done;
   logic            ecall_write;
   logic [31:0]     ecall_result;
   logic            ecall_wait;
   logic            input_wait;
   logic [31:0]     seg_data;
   logic            halted;

   int tests = 0;
   int fails = 0;

   ecall_io_unit #(
      .SW_W(SW_W),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .rst(rst), .ecall(ecall), .a0(a0), .a7(a7),
      .switches(switches), .button(button),
      .ecall_done(ecall_done), .ecall_write(ecall_write), .ecall_result(ecall_result),
      .ecall_wait(ecall_wait), .input_wait(input_wait), .seg_data(seg_data), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a7;
      logic [31:0] a0;
      logic [31:0] exp_seg;
   } svc_vec_t;

   typedef struct {
      logic [31:0]     a7;
      logic [SW_W-1:0] sw;
      logic [31:0]     exp_res;
   } rd_vec_t;

   svc_vec_t svc[5];
   rd_vec_t  rd[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_done"},   32'(ecall_done),  32'd0);
      check({tag, "_write"},  32'(ecall_write), 32'd0);
      check({tag, "_result"}, ecall_result,     32'd0);
      check({tag, "_ewait"},  32'(ecall_wait),  32'd0);
      check({tag, "_iwait"},  32'(input_wait),  32'd0);
      check({tag, "_seg"},    seg_data,         32'd0);
      check({tag, "_halted"}, 32'(halted),      32'd0);
   endtask

   task automatic do_read(input logic [31:0] a7_v, input logic [SW_W-1:0] sw_v,
                          input logic [31:0] exp_res, input int idx);
      int done_cnt = 0;
      int lat = 0;
      bit write_ok = 1'b1;
      bit iw_ok = 1'b1;
      a7 = a7_v; switches = sw_v; a0 = 32'hAAAA5555; ecall = 1'b1;
      tick();
      check($sformatf("rd%0d_iwait_set", idx), 32'(input_wait), 32'd1);
      check($sformatf("rd%0d_ewait_set", idx), 32'(ecall_wait), 32'd1);
      ecall = 1'b0; a7 = 32'd1; a0 = 32'h0;
      repeat (3) tick();
      button = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == 10) button = 1'b0;
         if (ecall_done) begin
            done_cnt++;
            if (lat == 0) lat = k;
            if (!ecall_write) write_ok = 1'b0;
         end else if (done_cnt == 0 && !input_wait) begin
            iw_ok = 1'b0;
         end
      end
      check($sformatf("rd%0d_done_count", idx), 32'(done_cnt), 32'd1);
      check($sformatf("rd%0d_write_with_done", idx), 32'(write_ok), 32'd1);
      check($sformatf("rd%0d_iwait_until_done", idx), 32'(iw_ok), 32'd1);
      check($sformatf("rd%0d_latency_in_range", idx), 32'(lat >= DB + 2 && lat <= DB + 4), 32'd1);
      check($sformatf("rd%0d_result", idx), ecall_result, exp_res);
      check($sformatf("rd%0d_iwait_clear", idx), 32'(input_wait), 32'd0);
      $display("[TB] read a7=%0d sw=0x%02h -> result=0x%08h latency=%0d", a7_v, sw_v, ecall_result, lat);
   endtask

   initial begin
      int cnt;
      logic [31:0] seg_hold;

      svc[0] = '{32'd1,  32'h1234ABCD, 32'h1234ABCD};
      svc[1] = '{32'd4,  32'hDEADBEEF, 32'h1234ABCD};
      svc[2] = '{32'd1,  32'h00000000, 32'h00000000};
      svc[3] = '{32'd0,  32'h11111111, 32'h00000000};
      svc[4] = '{32'd1,  32'h89ABCDEF, 32'h89ABCDEF};

      rd[0] = '{32'd5, 8'hF3, 32'h000000F3};
      rd[1] = '{32'd6, 8'hF3, 32'hFFFFFFF3};
      rd[2] = '{32'd6, 8'h73, 32'h00000073};
      rd[3] = '{32'd5, 8'h00, 32'h00000000};
      rd[4] = '{32'd5, 8'h80, 32'h00000080};
      rd[5] = '{32'd6, 8'h80, 32'hFFFFFF80};

      // Reset state
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      repeat (10) tick();

      // Print and NOP services
      for (int i = 0; i < 5; i++) begin
         a7 = svc[i].a7; a0 = svc[i].a0; ecall = 1'b1;
         tick();
         check($sformatf("svc%0d_done", i),  32'(ecall_done),  32'd1);
         check($sformatf("svc%0d_write", i), 32'(ecall_write), 32'd0);
         check($sformatf("svc%0d_seg", i),   seg_data,         svc[i].exp_seg);
         ecall = 1'b0;
         tick();
         check($sformatf("svc%0d_done_pulse", i), 32'(ecall_done), 32'd0);
         check($sformatf("svc%0d_ewait_idle", i), 32'(ecall_wait), 32'd0);
         $display("[TB] service a7=%0d a0=0x%08h -> seg=0x%08h", svc[i].a7, svc[i].a0, seg_data);
      end

      // Reads
      for (int i = 0; i < 6; i++) do_read(rd[i].a7, rd[i].sw, rd[i].exp_res, i);

      // Result is held across a print
      a7 = 32'd1; a0 = 32'h0BADF00D; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      tick();
      check("result_held", ecall_result, 32'hFFFFFF80);
      check("print_after_read_seg", seg_data, 32'h0BADF00D);
      $display("[TB] print 0x0BADF00D, result held 0x%08h", ecall_result);

      // Held press with glitches, then a clean release and press
      button = 1'b1;
      repeat (10) tick();
      a7 = 32'd5; switches = 8'h3C; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      cnt = 0;
      repeat (3) begin
         button = 1'b0;
         repeat (2) begin tick(); if (ecall_done) cnt++; end
         button = 1'b1;
         repeat (2) begin tick(); if (ecall_done) cnt++; end
      end
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      check("bounce_no_done", 32'(cnt), 32'd0);
      check("bounce_still_waiting", 32'(input_wait), 32'd1);
      button = 1'b0;
      repeat (8) begin tick(); if (ecall_done) cnt++; end
      button = 1'b1;
      repeat (12) begin tick(); if (ecall_done) cnt++; end
      button = 1'b0;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      check("bounce_one_done", 32'(cnt), 32'd1);
      check("bounce_result", ecall_result, 32'h0000003C);
      $display("[TB] bounce/held read -> done pulses=%0d result=0x%08h", cnt, ecall_result);

      // Press held across reset needs release and re-press
      button = 1'b1; rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      a7 = 32'd5; switches = 8'h5A; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      cnt = 0;
      repeat (20) begin tick(); if (ecall_done) cnt++; end
      check("held_reset_no_done", 32'(cnt), 32'd0);
      button = 1'b0;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      button = 1'b1;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      button = 1'b0;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      check("held_reset_one_done", 32'(cnt), 32'd1);
      check("held_reset_result", ecall_result, 32'h0000005A);
      $display("[TB] press held over reset -> done pulses=%0d result=0x%08h", cnt, ecall_result);

      // Exit and halt
      a7 = 32'd1; a0 = 32'h0000BEEF; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      tick();
      seg_hold = seg_data;
      a7 = 32'd10; ecall = 1'b1;
      tick();
      check("exit_halted", 32'(halted), 32'd1);
      check("exit_no_done", 32'(ecall_done), 32'd0);
      check("exit_ewait", 32'(ecall_wait), 32'd0);
      a7 = 32'd1; a0 = 32'h55555555;
      cnt = 0;
      repeat (5) begin tick(); if (ecall_done) cnt++; end
      ecall = 1'b0;
      button = 1'b1;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      button = 1'b0;
      check("halt_ignores_done", 32'(cnt), 32'd0);
      check("halt_seg_kept", seg_data, seg_hold);
      check("halt_kept", 32'(halted), 32'd1);
      rst = 1'b1;
      tick();
      check("halt_rst_halted", 32'(halted), 32'd0);
      check("halt_rst_seg", seg_data, 32'd0);
      rst = 1'b0;
      repeat (10) tick();
      $display("[TB] exit -> halted, ignored ecall, released by reset");

      // Reset in the middle of a read
      a7 = 32'd1; a0 = 32'hCAFEF00D; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      tick();
      check("midrd_seg_before", seg_data, 32'hCAFEF00D);
      a7 = 32'd6; switches = 8'hA5; ecall = 1'b1;
      tick();
      ecall = 1'b0;
      repeat (4) tick();
      check("midrd_iwait", 32'(input_wait), 32'd1);
      rst = 1'b1;
      tick();
      check_all_zero("midrd_rst");
      rst = 1'b0;
      repeat (8) tick();
      button = 1'b1;
      cnt = 0;
      repeat (10) begin tick(); if (ecall_done) cnt++; end
      button = 1'b0;
      repeat (15) begin tick(); if (ecall_done) cnt++; end
      check("midrd_press_no_done", 32'(cnt), 32'd0);
      check("midrd_idle_ewait", 32'(ecall_wait), 32'd0);
      $display("[TB] reset mid-read -> done pulses after press=%0d", cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
